uart_pixel_rx_stream: RTL and testbench

Parametrised UART pixel receiver: samples a serial line, buffers bytes in an internal FIFO and assembles them into fixed-width pixels with a running frame address and end-of-frame pulse. Generalises our 24-bit UART pixel path to configurable bytes-per-pixel, frame size, baud rate and FIFO depth. Adds framing-error detection, overflow flagging and inter-byte timeout resynchronisation. Sits between the board RX pin and the frame-buffer write port; `cam_mode` hands the buffer to the camera path.

---
 rtl/uart_rx_pkg.sv | 15 +
 rtl/uart_pixel_rx_stream_if.sv | 18 +
 rtl/uart_byte_rx.sv | 86 ++++++++
 rtl/uart_pixel_rx_stream.sv | 165 ++++++++++++++++
 tb/tb_uart_pixel_rx_stream.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and elaboration helpers for the UART pixel receiver.
package uart_rx_pkg;

   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
   typedef enum logic [1:0] {AsmIdle, AsmCollect, AsmEmit} asm_state_e;

   function automatic int unsigned bit_cyc(input int unsigned clk_hz, input int unsigned baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

   function automatic int unsigned addr_w(input int unsigned frame_pixels);
      return (frame_pixels > 1) ? $clog2(frame_pixels) : 1;
   endfunction

endpackage

// File: rtl/uart_pixel_rx_stream_if.sv
// Pixel write port and status flags from the UART pixel receiver to the frame buffer.
interface uart_pixel_rx_stream_if #(
   parameter int unsigned PIX_W  = 24,
   parameter int unsigned ADDR_W = 16
);
   logic [PIX_W-1:0]  pixel_data;
   logic              pixel_valid;
   logic [ADDR_W-1:0] pixel_addr;
   logic              frame_done;
   logic              framing_err;
   logic              overflow;
   logic              timeout;

   modport master (output pixel_data, pixel_valid, pixel_addr, frame_done, framing_err,
                   overflow, timeout);
   modport slave  (input  pixel_data, pixel_valid, pixel_addr, frame_done, framing_err,
                   overflow, timeout);
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-FF synchroniser, mid-bit sampling, stop-bit framing check.
module uart_byte_rx
   import uart_rx_pkg::*;
#(
   parameter int unsigned BIT_CYC = 868
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       framing_err_o
);
   localparam int unsigned CNT_W = $clog2(BIT_CYC);
   localparam logic [CNT_W-1:0] HalfLast = CNT_W'(BIT_CYC / 2 - 1);
   localparam logic [CNT_W-1:0] FullLast = CNT_W'(BIT_CYC - 1);

   rx_state_e        state_q, state_d;
   logic             rx_meta_q, rx_sync_q, rx_prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
         state_q   <= RxIdle;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
      end else begin
         rx_meta_q <= rx_i;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q + 1'b1;
      bit_d         = bit_q;
      shift_d       = shift_q;
      byte_valid_o  = 1'b0;
      framing_err_o = 1'b0;
      unique case (state_q)
         RxIdle: begin
            cnt_d = '0;
            bit_d = '0;
            if (rx_prev_q && !rx_sync_q) state_d = RxStart;
         end
         RxStart: begin
            // A start bit that is high again at mid-bit was a glitch.
            if (cnt_q == HalfLast) begin
               cnt_d   = '0;
               state_d = rx_sync_q ? RxIdle : RxData;
            end
         end
         RxData: begin
            if (cnt_q == FullLast) begin
               cnt_d   = '0;
               shift_d = {rx_sync_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = RxStop;
            end
         end
         RxStop: begin
            if (cnt_q == FullLast) begin
               cnt_d         = '0;
               state_d       = RxIdle;
               byte_valid_o  = rx_sync_q;
               framing_err_o = !rx_sync_q;
            end
         end
         default: state_d = RxIdle;
      endcase
   end

   assign byte_o = shift_q;

endmodule

// File: rtl/uart_pixel_rx_stream.sv
// UART pixel receiver: byte RX, byte FIFO and pixel assembler with frame addressing.
// Optional inter-byte timeout resync is compiled in with UART_RX_TIMEOUT_EN.
module uart_pixel_rx_stream
   import uart_rx_pkg::*;
#(
   parameter int unsigned CLK_HZ          = 100_000_000,
   parameter int unsigned BAUD            = 115200,
   parameter int unsigned BYTES_PER_PIXEL = 3,
   parameter int unsigned FRAME_PIXELS    = 40800,
   parameter int unsigned FIFO_DEPTH      = 16
`ifdef UART_RX_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYC   = 16 * bit_cyc(CLK_HZ, BAUD) * 10
`endif
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rx,
   input  logic                   cam_mode,
   uart_pixel_rx_stream_if.master pix_if
);
   localparam int unsigned BIT_CYC = bit_cyc(CLK_HZ, BAUD);
   localparam int unsigned PIX_W   = 8 * BYTES_PER_PIXEL;
   localparam int unsigned ADDR_W  = addr_w(FRAME_PIXELS);
   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam logic [1:0]        IdxLast  = 2'(BYTES_PER_PIXEL - 1);
   localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(FRAME_PIXELS - 1);

   logic [7:0] rx_byte;
   logic       rx_byte_valid, rx_framing_err;

   uart_byte_rx #(.BIT_CYC(BIT_CYC)) u_byte_rx (
      .clk_i        (clk),
      .rst_ni       (reset),
      .rx_i         (rx),
      .byte_o       (rx_byte),
      .byte_valid_o (rx_byte_valid),
      .framing_err_o(rx_framing_err)
   );

   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d, framing_err_q;
   logic             fifo_empty, fifo_full, push, pop;

   asm_state_e        state_q, state_d;
   logic [PIX_W-1:0]  pix_q, pix_d;
   logic [1:0]        idx_q, idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              timeout_q, timeout_d;
`ifdef UART_RX_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] tcnt_q, tcnt_d;
`endif

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));

   always_comb pop  = (state_q == AsmCollect) && !fifo_empty && !cam_mode;
   // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
   always_comb push = rx_byte_valid && !cam_mode && (!fifo_full || pop);

   always_comb begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(push);
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
      count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
      overflow_d = overflow_q | (rx_byte_valid && !cam_mode && fifo_full && !pop);
      if (cam_mode) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end
   end

   always_comb begin
      state_d   = state_q;
      pix_d     = pix_q;
      idx_d     = idx_q;
      addr_d    = addr_q;
      timeout_d = 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      tcnt_d    = '0;
`endif
      if (cam_mode) begin
         state_d = AsmIdle;
         idx_d   = '0;
         addr_d  = '0;
      end else begin
         unique case (state_q)
            AsmIdle: if (!fifo_empty) state_d = AsmCollect;
            AsmCollect: begin
               if (pop) begin
                  pix_d = (pix_q << 8) | PIX_W'(mem_q[rd_ptr_q]);
                  idx_d = idx_q + 2'd1;
                  if (idx_q == IdxLast) begin
                     idx_d   = '0;
                     state_d = AsmEmit;
                  end
               end
`ifdef UART_RX_TIMEOUT_EN
               else if (idx_q != '0) begin
                  tcnt_d = tcnt_q + 1'b1;
                  if (tcnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                     tcnt_d    = '0;
                     timeout_d = 1'b1;
                     idx_d     = '0;
                     state_d   = AsmIdle;
                  end
               end
`endif
            end
            AsmEmit: begin
               addr_d  = (addr_q == AddrLast) ? '0 : addr_q + 1'b1;
               state_d = fifo_empty ? AsmIdle : AsmCollect;
            end
            default: state_d = AsmIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= rx_byte;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         overflow_q    <= 1'b0;
         framing_err_q <= 1'b0;
         state_q       <= AsmIdle;
         pix_q         <= '0;
         idx_q         <= '0;
         addr_q        <= '0;
         timeout_q     <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
         tcnt_q        <= '0;
`endif
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         overflow_q    <= overflow_d;
         framing_err_q <= rx_framing_err;
         state_q       <= state_d;
         pix_q         <= pix_d;
         idx_q         <= idx_d;
         addr_q        <= addr_d;
         timeout_q     <= timeout_d;
`ifdef UART_RX_TIMEOUT_EN
         tcnt_q        <= tcnt_d;
`endif
      end
   end

   assign pix_if.pixel_data  = pix_q;
   assign pix_if.pixel_valid = (state_q == AsmEmit);
   assign pix_if.pixel_addr  = addr_q;
   assign pix_if.frame_done  = (state_q == AsmEmit) && (addr_q == AddrLast);
   assign pix_if.framing_err = framing_err_q;
   assign pix_if.overflow    = overflow_q;
   assign pix_if.timeout     = timeout_q;

endmodule

// File: tb/tb_uart_pixel_rx_stream.sv
// Scoreboard bench for uart_pixel_rx_stream: 10-cycle bit period, 3-byte pixels, 4-pixel frames.
module tb_uart_pixel_rx_stream;

   localparam int unsigned BIT = 10;

   typedef struct packed {
      logic [23:0] data;
      logic [1:0]  addr;
      logic        fd;
   } pix_t;

   logic clk = 1'b0;
   logic reset, rx, cam_mode;
   logic [1:0] exp_addr;
   pix_t sb[$];
   int checks = 0;
   int errors = 0;
   int fe_cycles = 0;
   int to_cycles = 0;

   uart_pixel_rx_stream_if #(.PIX_W(24), .ADDR_W(2)) pix_if ();

   uart_pixel_rx_stream #(
      .CLK_HZ         (1_000_000),
      .BAUD           (100_000),
      .BYTES_PER_PIXEL(3),
      .FRAME_PIXELS   (4),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .rx      (rx),
      .cam_mode(cam_mode),
      .pix_if  (pix_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic expect_pixel(input logic [23:0] data);
      sb.push_back('{data: data, addr: exp_addr, fd: (exp_addr == 2'd3)});
      exp_addr = exp_addr + 2'd1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT) @(negedge clk);
      end
      rx = stop;
      repeat (BIT) @(negedge clk);
      rx = 1'b1;
      repeat (2 * BIT) @(negedge clk);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
      check(name, sb.size(), 0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   // Monitor: pops the scoreboard on every pixel strobe, counts pulse cycles.
   always @(negedge clk) begin
      pix_t e;
      if (pix_if.framing_err) fe_cycles++;
      if (pix_if.timeout) to_cycles++;
      if (pix_if.pixel_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pixel: got data %06h addr %0d, want no pixel",
                     pix_if.pixel_data, pix_if.pixel_addr);
         end else begin
            e = sb.pop_front();
            check("pixel_data", 32'(pix_if.pixel_data), 32'(e.data));
            check("pixel_addr", 32'(pix_if.pixel_addr), 32'(e.addr));
            check("frame_done", 32'(pix_if.frame_done), 32'(e.fd));
         end
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: got no finish, want finish before 500000 ns");
      $fatal(1, "watchdog");
   end

   initial begin
      rx = 1'b1;
      cam_mode = 1'b0;
      reset = 1'b0;
      exp_addr = 2'd0;
      repeat (4) @(negedge clk);
      check("rst_pixel_valid", 32'(pix_if.pixel_valid), 0);
      check("rst_pixel_addr", 32'(pix_if.pixel_addr), 0);
      check("rst_pixel_data", 32'(pix_if.pixel_data), 0);
      check("rst_frame_done", 32'(pix_if.frame_done), 0);
      check("rst_framing_err", 32'(pix_if.framing_err), 0);
      check("rst_overflow", 32'(pix_if.overflow), 0);
      check("rst_timeout", 32'(pix_if.timeout), 0);
      reset = 1'b1;
      repeat (5) @(negedge clk);

      // Single pixel.
      expect_pixel(24'h123456);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h56, 1'b1);
      drain("drain_single");

      // Full frame from a fresh reset, then wrap to address 0.
      do_reset();
      exp_addr = 2'd0;
      for (int p = 0; p < 4; p++)
         expect_pixel({8'(3 * p), 8'(3 * p + 1), 8'(3 * p + 2)});
      for (int i = 0; i < 12; i++) send_byte(8'(i), 1'b1);
      drain("drain_frame");
      expect_pixel(24'hC0C1C2);
      send_byte(8'hC0, 1'b1);
      send_byte(8'hC1, 1'b1);
      send_byte(8'hC2, 1'b1);
      drain("drain_wrap");

      // Framing error: byte dropped, one-cycle pulse.
      fe_cycles = 0;
      send_byte(8'hA5, 1'b0);
      repeat (20) @(negedge clk);
      check("framing_err_cycles", fe_cycles, 1);

      // Partial pixel followed by a long idle gap.
      to_cycles = 0;
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      repeat (1700) @(negedge clk);
`ifdef UART_RX_TIMEOUT_EN
      check("timeout_cycles", to_cycles, 1);
      expect_pixel(24'hAABBCC);
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b1);
      send_byte(8'hCC, 1'b1);
`else
      check("timeout_cycles", to_cycles, 0);
      expect_pixel(24'h1122AA);
      expect_pixel(24'hBBCCDD);
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b1);
      send_byte(8'hCC, 1'b1);
      send_byte(8'hDD, 1'b1);
`endif
      drain("drain_after_gap");

      // Camera mode: bytes flushed, new frame starts at address 0.
      cam_mode = 1'b1;
      for (int i = 0; i < 5; i++) send_byte(8'h51 + 8'(i), 1'b1);
      repeat (5) @(negedge clk);
      cam_mode = 1'b0;
      exp_addr = 2'd0;
      expect_pixel(24'h313233);
      send_byte(8'h31, 1'b1);
      send_byte(8'h32, 1'b1);
      send_byte(8'h33, 1'b1);
      drain("drain_cam");

      // Overflow with the assembler stalled.
      force dut.pop = 1'b0;
      for (int i = 0; i < 4; i++) send_byte(8'h41 + 8'(i), 1'b1);
      check("overflow_when_full", 32'(pix_if.overflow), 0);
      send_byte(8'h45, 1'b1);
      check("overflow_set", 32'(pix_if.overflow), 1);
      repeat (50) @(negedge clk);
      check("overflow_sticky", 32'(pix_if.overflow), 1);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      release dut.pop;
      check("overflow_reset", 32'(pix_if.overflow), 0);
      check("addr_reset", 32'(pix_if.pixel_addr), 0);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      check("overflow_after_reset", 32'(pix_if.overflow), 0);
      check("scoreboard_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
